// File: rtl/kakacpu_pkg.sv
// -----------------------------------------------------------------------------
// kakacpu_pkg
// Shared definitions for the kakacpu decode stage:
//   - RV32I major opcode constants
//   - alu_op_t : ALU operation selector handed to execute
//   - decoded_t: bundle of everything the decoder extracts from one word
//   - alu_from_funct: funct3/alt-bit to ALU operation mapping shared by OP
//     and OP-IMM
// -----------------------------------------------------------------------------
package kakacpu_pkg;

    localparam int ILEN = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [ILEN-1:0] imm;
        logic [2:0]      funct3;
        alu_op_t         alu_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            use_imm;
        logic            use_pc;
        logic            illegal;
    } decoded_t;

    // alt selects SUB over ADD and SRA over SRL; callers decide when the
    // alternate bit is meaningful (never for ADDI, whose bit 30 is immediate).
    function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational RV32I decoder: one instruction word in, one decoded_t
// bundle out.
// Ports:
//   i_instr [31:0]  instruction word
//   o_dec           decoded fields, immediate, ALU op and control flags
// -----------------------------------------------------------------------------
module instr_decoder
    import kakacpu_pkg::*;
(
    input  logic [ILEN-1:0] i_instr,
    output decoded_t        o_dec
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [ILEN-1:0] w_imm_i;
    logic [ILEN-1:0] w_imm_s;
    logic [ILEN-1:0] w_imm_b;
    logic [ILEN-1:0] w_imm_u;
    logic [ILEN-1:0] w_imm_j;
    logic            w_bad_form;
    decoded_t        w_raw;
    logic            w_field_ok;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};

    // Compressed-encoding bits and the all-zero word are rejected regardless
    // of what the opcode field happens to say.
    assign w_bad_form = (i_instr[1:0] != 2'b11) || (i_instr == '0);

    always_comb begin
        w_raw        = '0;
        w_raw.rd     = i_instr[11:7];
        w_raw.rs1    = i_instr[19:15];
        w_raw.rs2    = i_instr[24:20];
        w_raw.funct3 = w_funct3;
        w_raw.alu_op = ALU_ADD;
        w_field_ok   = 1'b1;

        case (w_opcode)
            OPC_LUI: begin
                w_raw.imm       = w_imm_u;
                w_raw.alu_op    = ALU_PASS_B;
                w_raw.use_imm   = 1'b1;
                w_raw.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_raw.imm       = w_imm_u;
                w_raw.use_imm   = 1'b1;
                w_raw.use_pc    = 1'b1;
                w_raw.reg_write = 1'b1;
            end
            OPC_JAL: begin
                w_raw.imm       = w_imm_j;
                w_raw.use_imm   = 1'b1;
                w_raw.use_pc    = 1'b1;
                w_raw.jump      = 1'b1;
                w_raw.reg_write = 1'b1;
            end
            OPC_JALR: begin
                w_raw.imm       = w_imm_i;
                w_raw.use_imm   = 1'b1;
                w_raw.jump      = 1'b1;
                w_raw.reg_write = 1'b1;
                w_field_ok      = (w_funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                // ALU compares by subtraction; target is pc + imm.
                w_raw.imm    = w_imm_b;
                w_raw.alu_op = ALU_SUB;
                w_raw.use_pc = 1'b1;
                w_raw.branch = 1'b1;
                w_field_ok   = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            end
            OPC_LOAD: begin
                w_raw.imm       = w_imm_i;
                w_raw.use_imm   = 1'b1;
                w_raw.mem_read  = 1'b1;
                w_raw.reg_write = 1'b1;
                w_field_ok      = (w_funct3 != 3'b011) && (w_funct3 != 3'b110)
                                  && (w_funct3 != 3'b111);
            end
            OPC_STORE: begin
                w_raw.imm       = w_imm_s;
                w_raw.use_imm   = 1'b1;
                w_raw.mem_write = 1'b1;
                w_field_ok      = (w_funct3 == 3'b000) || (w_funct3 == 3'b001)
                                  || (w_funct3 == 3'b010);
            end
            OPC_OP_IMM: begin
                w_raw.imm       = w_imm_i;
                w_raw.use_imm   = 1'b1;
                w_raw.reg_write = 1'b1;
                // Only the right shift carries an alternate form; for the
                // other funct3 values bit 30 is part of the immediate.
                w_raw.alu_op    = alu_from_funct(w_funct3,
                                                 (w_funct3 == 3'b101) && w_funct7[5]);
                if (w_funct3 == 3'b001)
                    w_field_ok = (w_funct7 == FUNCT7_BASE);
                else if (w_funct3 == 3'b101)
                    w_field_ok = (w_funct7 == FUNCT7_BASE) || (w_funct7 == FUNCT7_ALT);
            end
            OPC_OP: begin
                w_raw.reg_write = 1'b1;
                w_raw.alu_op    = alu_from_funct(w_funct3, w_funct7[5]);
                // The alternate funct7 exists only for SUB and SRA.
                w_field_ok      = (w_funct7 == FUNCT7_BASE)
                                  || ((w_funct7 == FUNCT7_ALT)
                                      && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            end
            OPC_MISC_MEM: begin
                // FENCE / FENCE.I retire as no-ops in this in-order core.
                w_raw.imm     = w_imm_i;
                w_raw.use_imm = 1'b1;
                w_field_ok    = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
            end
            OPC_SYSTEM: begin
                // System words are flagged illegal so execute raises a trap.
                w_raw.imm     = w_imm_i;
                w_raw.use_imm = 1'b1;
                w_field_ok    = 1'b0;
            end
            default: begin
                w_field_ok = 1'b0;
            end
        endcase

        w_raw.illegal = w_bad_form || !w_field_ok;

        o_dec = w_raw;
        if (w_raw.rd == 5'd0)
            o_dec.reg_write = 1'b0;
        // An illegal word must have no architectural side effects; it still
        // travels down the pipe so execute can raise the trap.
        if (w_raw.illegal) begin
            o_dec.reg_write = 1'b0;
            o_dec.mem_read  = 1'b0;
            o_dec.mem_write = 1'b0;
            o_dec.branch    = 1'b0;
            o_dec.jump      = 1'b0;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
// kakacpu decode pipeline stage (1-cycle latency). Registers the decode of
// each accepted fetch transfer, back-pressures fetch while execute stalls,
// and drops its contents on a taken branch.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_input/data_input/pc_input   fetch transfer
//   stall_output             tell fetch to hold its transfer
//   stall_input              execute cannot accept this cycle
//   branch_input             execute redirect: flush this stage
//   valid_output/pc_output   registered bundle valid and its pc
//   rd/rs1/rs2/imm/funct3/alu_op      decoded operands
//   reg_write..illegal       control flags
//   decoded_count            instructions accepted since reset (wraps)
// -----------------------------------------------------------------------------
module instruction_decode
    import kakacpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_input,
    input  logic [31:0]        data_input,
    input  logic [XLEN-1:0]    pc_input,
    output logic               stall_output,
    input  logic               stall_input,
    input  logic               branch_input,
    output logic               valid_output,
    output logic [XLEN-1:0]    pc_output,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [XLEN-1:0]    imm,
    output logic [2:0]         funct3,
    output alu_op_t            alu_op,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               branch,
    output logic               jump,
    output logic               use_imm,
    output logic               use_pc,
    output logic               illegal,
    output logic [COUNT_W-1:0] decoded_count
);

    decoded_t           w_dec;
    logic               w_accept;

    logic               r_valid;
    logic [XLEN-1:0]    r_pc;
    decoded_t           r_dec;
    logic [COUNT_W-1:0] r_count;

    instr_decoder u_decoder (
        .i_instr (data_input),
        .o_dec   (w_dec)
    );

    // The stage is free when empty or when execute is draining it this cycle.
    assign w_accept     = valid_input && (!r_valid || !stall_input);
    assign stall_output = r_valid && stall_input;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_dec   <= '0;
            r_count <= '0;
        end else if (branch_input) begin
            // Wrong-path work is discarded, stalled or not; nothing is counted.
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pc    <= pc_input;
            r_dec   <= w_dec;
            r_count <= r_count + COUNT_W'(1);
        end else if (!stall_input) begin
            // Execute consumed the bundle and nothing new arrived; data is
            // left stale since valid_output qualifies it.
            r_valid <= 1'b0;
        end
    end

    assign valid_output  = r_valid;
    assign pc_output     = r_pc;
    assign rd            = r_dec.rd;
    assign rs1           = r_dec.rs1;
    assign rs2           = r_dec.rs2;
    assign imm           = XLEN'(signed'(r_dec.imm));
    assign funct3        = r_dec.funct3;
    assign alu_op        = r_dec.alu_op;
    assign reg_write     = r_dec.reg_write;
    assign mem_read      = r_dec.mem_read;
    assign mem_write     = r_dec.mem_write;
    assign branch        = r_dec.branch;
    assign jump          = r_dec.jump;
    assign use_imm       = r_dec.use_imm;
    assign use_pc        = r_dec.use_pc;
    assign illegal       = r_dec.illegal;
    assign decoded_count = r_count;

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Pipeline stage directly downstream of instruction_fetch in kakacpu.
- Registers one fetched RV32I instruction per accepted transfer and decodes it into register indices, sign-extended immediate, ALU op and control flags for the execute stage.
- Propagates backpressure to fetch and squashes its contents on a taken branch.
- Latency 1 cycle.

Parameters:
- XLEN, 32, datapath and immediate width.
- COUNT_W, 32, width of the accepted-instruction debug counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- valid_input  in  1  fetch presents an instruction this cycle
- data_input  in  32  instruction word (fetch data_output)
- pc_input  in  XLEN  address of data_input
- stall_output  out  1  to fetch stall_input; fetch must hold data_input/pc_input
- stall_input  in  1  execute cannot accept this cycle
- branch_input  in  1  execute redirect; flush this stage
- valid_output  out  1  decoded bundle valid
- pc_output  out  XLEN  registered pc_input
- rd, rs1, rs2  out  5 each  register indices
- imm  out  XLEN  sign-extended immediate
- funct3  out  3  raw funct3, for branch/load/store width
- alu_op  out  4  alu_op_t
- reg_write, mem_read, mem_write, branch, jump, use_imm, use_pc, illegal  out  1 each  control flags
- decoded_count  out  COUNT_W  instructions accepted since reset

Behaviour:
- Reset (rst=1 at an edge): valid_output=0, every data and flag output=0, decoded_count=0. Reset overrides flush and accept.
- accept = valid_input && (!valid_output || !stall_input).
- stall_output = valid_output && stall_input. Combinational; no skid buffer.
- Priority per edge: rst, then branch_input, then accept, then hold.
- branch_input=1: next valid_output=0. Any concurrent input is dropped and not counted, even if stall_input=1.
- Accept: all outputs load the decode of data_input/pc_input; valid_output=1; decoded_count+1, wrapping at 2^COUNT_W.
- No accept, valid_output && stall_input: all outputs hold bit-exact.
- No accept, !stall_input: valid_output goes to 0. Data outputs may hold stale values.
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (FENCE as NOP), SYSTEM (ECALL/EBREAK raise illegal=1 for now).
- Immediates follow the standard I/S/B/U/J formats, with bit 31 sign-extended. U-type is imm[31:12],12'b0. R-type imm=0.
- alu_op assignment:
  - ADD for ADD/ADDI/loads/stores/AUIPC/JAL/JALR.
  - SUB for SUB and branches.
  - PASS_B for LUI.
  - Shifts, compares and logic by funct3 and funct7[5].
- use_pc=1 for AUIPC/JAL/branch. use_imm=1 for all non-R, non-branch opcodes.
- reg_write=1 for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP, forced 0 when rd==0.
- illegal=1 when any of the following holds:
  - data_input[1:0]!=2'b11
  - unknown opcode
  - invalid funct3/funct7 combination (e.g. OP with funct7 not in {0x00,0x20}; SLLI with funct7!=0)
  - word is 32'h0
- When illegal=1: reg_write, mem_read, mem_write, branch and jump are forced 0, and valid_output still asserts so execute can trap.

Decomposition:
- kakacpu_pkg holds: opcode localparams; alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B); decoded_t struct bundling the decode outputs.
- Combinational sub-module instr_decoder (data_input -> decoded_t).
- instruction_decode itself holds only the pipeline register, handshake, flush and counter.

Test Plan:
- Accept addi: 0x00500093 with valid_input=1, pc 0x0 -> next cycle valid_output=1, rd=1, rs1=0, imm=5, alu_op=ADD, use_imm=1, reg_write=1, decoded_count=1.
- Load imm: 0xFFC0A103 (lw x2,-4(x1)) -> rd=2, rs1=1, imm=0xFFFFFFFC, mem_read=1, funct3=3'b010.
- Branch and LUI: 0xFE208CE3 (beq x1,x2,-8) -> imm=0xFFFFFFF8, branch=1, alu_op=SUB, use_pc=1, reg_write=0. Then 0x123452B7 (lui x5) -> imm=0x12345000, alu_op=PASS_B.
- Stall: hold stall_input=1 for 3 cycles with a valid entry -> stall_output=1, outputs frozen, decoded_count unchanged. Release -> the next instruction loads in the same edge.
- Flush and reset: branch_input=1 with valid_input=1 and stall_input=1 -> valid_output=0 next cycle, count unchanged. Also rst=1 mid-stream -> all outputs 0 next cycle.
- Illegal: 0x00000000, 0x00000013 with bits[1:0] forced to 00, and 0x40001033 (funct7 0x20 with SLL) -> valid_output=1, illegal=1, all write/mem flags 0.
